// File: rtl/normalizer_pipe_if.sv
// Handshake bundle for normalizer_pipe (input side, output side and result fields).
// signed_mode exists only when NORMALIZE_SIGNED_EN is defined.
interface normalizer_pipe_if #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] opA;
`ifdef NORMALIZE_SIGNED_EN
    logic             signed_mode;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [CNTW-1:0]  count;
    logic             zero;

    modport master (
`ifdef NORMALIZE_SIGNED_EN
        output signed_mode,
`endif
        output in_valid, opA, out_ready,
        input  in_ready, out_valid, result, count, zero
    );

    modport slave (
`ifdef NORMALIZE_SIGNED_EN
        input  signed_mode,
`endif
        input  in_valid, opA, out_ready,
        output in_ready, out_valid, result, count, zero
    );
endinterface

// File: rtl/normalizer_pipe.sv
// Two-stage leading-zero normalizer: stage 1 strips whole zero bytes, stage 2 the remaining bits.
// Optional NORMALIZE_SIGNED_EN adds signed_mode (count redundant sign bits instead of zeros).
module normalizer_pipe #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input logic              clk,
    input logic              resetn,
    normalizer_pipe_if.slave bus
);
    logic             s1_valid, s2_valid, s2_adv, accept;
    logic [WIDTH-1:0] s1_data;
    logic [CNTW-1:0]  s1_cnt;
    logic             s1_zero;
    logic [WIDTH-1:0] result_q;
    logic [CNTW-1:0]  count_q;
    logic             zero_q;

    logic [WIDTH-1:0] srch;
    logic [1:0]       k;
    logic [7:0]       fine_top;
    logic [3:0]       f;
    logic [CNTW-1:0]  fine_cnt;
    logic [WIDTH-1:0] fine_res;
`ifdef NORMALIZE_SIGNED_EN
    logic             s1_sgn, s1_sign;
    logic [7:0]       s1_top;
    logic [WIDTH-1:0] srch_sh;
    logic [WIDTH:0]   ext;
`endif

    function automatic logic [3:0] lzc8(input logic [7:0] b);
        logic [3:0] r;
        r = 4'd8;
        for (int i = 0; i < 8; i++)
            if (b[i]) r = 4'(7 - i);
        return r;
    endfunction

    assign s2_adv       = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_adv;
    assign accept       = bus.in_valid && bus.in_ready;

    // Coarse search: count leading zero bytes of the search word, capped at 3.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        srch = bus.opA;
`ifdef NORMALIZE_SIGNED_EN
        if (bus.signed_mode) srch = bus.opA ^ {WIDTH{bus.opA[WIDTH-1]}};
`endif
        k = 2'd3;
        if (srch[31:24] != 8'd0)      k = 2'd0;
        else if (srch[23:16] != 8'd0) k = 2'd1;
        else if (srch[15:8] != 8'd0)  k = 2'd2;
`ifdef NORMALIZE_SIGNED_EN
        srch_sh = srch << {k, 3'b000};
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: data registers are reset as well, so result/count/zero read 0 straight after reset.
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_cnt   <= '0;
            s1_zero  <= 1'b0;
`ifdef NORMALIZE_SIGNED_EN
            s1_sgn   <= 1'b0;
            s1_sign  <= 1'b0;
            s1_top   <= '0;
`endif
        end else if (accept) begin
            // NOTE: sequential state uses <= so every flop samples the pre-edge values.
            s1_valid <= 1'b1;
            s1_data  <= bus.opA << {k, 3'b000};
            s1_cnt   <= CNTW'({k, 3'b000});
            s1_zero  <= (bus.opA == '0);
`ifdef NORMALIZE_SIGNED_EN
            s1_sgn   <= bus.signed_mode;
            s1_sign  <= bus.opA[WIDTH-1];
            s1_top   <= srch_sh[WIDTH-1 -: 8];
`endif
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Fine search on the top byte; a zero byte yields 8, which makes a zero search word total 32.
    always_comb begin
        fine_top = s1_data[WIDTH-1 -: 8];
`ifdef NORMALIZE_SIGNED_EN
        fine_top = s1_top;
`endif
        f        = lzc8(fine_top);
        fine_cnt = s1_cnt + CNTW'(f);
        fine_res = s1_data << f;
        if (s1_zero) begin
            fine_cnt = CNTW'(WIDTH);
            fine_res = '0;
        end
`ifdef NORMALIZE_SIGNED_EN
        // One shift short of the sign-flip point; the sign bit refills anything stage 1 shifted out.
        ext = {s1_sign, s1_data} << f;
        if (s1_sgn) begin
            fine_cnt = s1_cnt + CNTW'(f) - CNTW'(1);
            fine_res = ext[WIDTH:1];
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s2_valid <= 1'b0;
            result_q <= '0;
            count_q  <= '0;
            zero_q   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result_q <= fine_res;
                count_q  <= fine_cnt;
                zero_q   <= s1_zero;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.result    = result_q;
    assign bus.count     = count_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_normalizer_pipe.sv
// Self-checking bench for normalizer_pipe: directed cases plus random traffic against a queue model.
module tb_normalizer_pipe;
    typedef struct packed {
        logic [31:0] result;
        logic [5:0]  count;
        logic        zero;
    } exp_t;

    logic clk;
    logic resetn;
    int   checks = 0;
    int   errors = 0;
    logic acc;
    logic hold_chk;
    exp_t held;
    exp_t q[$];

    normalizer_pipe_if #(.WIDTH(32), .CNTW(6)) bus ();
    normalizer_pipe #(.WIDTH(32), .CNTW(6)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count leading zeros (or leading sign copies minus one) bit by bit.
    function automatic exp_t model(input logic [31:0] a, input logic sgn);
        exp_t        e;
        logic [31:0] x;
        int          n;
        x = (sgn && a[31]) ? ~a : a;
        n = 32;
        for (int i = 0; i < 32; i++)
            if (x[i]) n = 31 - i;
        if (sgn) n = n - 1;
        e.count  = 6'(n);
        e.result = (n >= 32) ? 32'd0 : (a << n);
        e.zero   = (a == 32'd0);
        return e;
    endfunction

    function automatic logic cur_sgn();
`ifdef NORMALIZE_SIGNED_EN
        return bus.signed_mode;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: observe handshakes at the falling edge, then move to just after the next rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        if (hold_chk) begin
            check("stall_result", bus.result, held.result);
            check("stall_count", bus.count, held.count);
            check("stall_zero", bus.zero, held.zero);
        end
        if (acc) q.push_back(model(bus.opA, cur_sgn()));
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", bus.out_valid, 1'b0);
            end else begin
                e = q.pop_front();
                check("out_result", bus.result, e.result);
                check("out_count", bus.count, e.count);
                check("out_zero", bus.zero, e.zero);
            end
        end
        hold_chk = bus.out_valid && !bus.out_ready;
        held     = '{bus.result, bus.count, bus.zero};
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        step();
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    logic [31:0] ops[3];
    logic [31:0] tmp;

    initial begin
        hold_chk      = 1'b0;
        held          = '0;
        acc           = 1'b0;
        resetn        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.opA       = '0;
        bus.out_ready = 1'b0;
`ifdef NORMALIZE_SIGNED_EN
        bus.signed_mode = 1'b0;
`endif
        #12;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_result", bus.result, 32'd0);
        check("rst_count", bus.count, 6'd0);
        check("rst_zero", bus.zero, 1'b0);
        resetn = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single operand, latency of two cycles.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.opA       = 32'h0001_0000;
        step();
        check("t1_accept", acc, 1'b1);
        bus.in_valid = 1'b0;
        check("t1_lat1_valid", bus.out_valid, 1'b0);
        step();
        check("t1_lat2_valid", bus.out_valid, 1'b1);
        check("t1_count", bus.count, 6'd15);
        check("t1_result", bus.result, 32'h8000_0000);
        check("t1_zero", bus.zero, 1'b0);
        drain();

        // Back-to-back operands including the zero case.
        ops = '{32'h0000_0001, 32'h8000_0000, 32'h0000_0000};
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.opA = ops[i];
            step();
            check("b2b_accept", acc, 1'b1);
        end
        drain();

        // Backpressure: two accepts fill the pipe, third operand is held off.
        bus.out_ready = 1'b0;
        ops = '{32'h0000_FF00, 32'h00F0_0000, 32'h1234_5678};
        bus.in_valid = 1'b1;
        bus.opA = ops[0];
        step();
        check("bp_accept0", acc, 1'b1);
        bus.opA = ops[1];
        step();
        check("bp_accept1", acc, 1'b1);
        bus.opA = ops[2];
        check("bp_in_ready", bus.in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_held", acc, 1'b0);
        end
        check("bp_out_valid", bus.out_valid, 1'b1);
        check("bp_count", bus.count, 6'd16);
        bus.out_ready = 1'b1;
        step();
        check("bp_accept2", acc, 1'b1);
        drain();

        // Reset with two operands in flight.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.opA       = 32'h0000_0001;
        step();
        bus.opA = 32'h0000_0100;
        step();
        bus.in_valid = 1'b0;
        resetn = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 1'b0);
        check("mid_rst_result", bus.result, 32'd0);
        check("mid_rst_count", bus.count, 6'd0);
        q.delete();
        hold_chk = 1'b0;
        #2;
        resetn = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_no_stale", bus.out_valid, 1'b0);
        end
        bus.in_valid = 1'b1;
        bus.opA      = 32'h0000_0100;
        step();
        bus.in_valid = 1'b0;
        step();
        check("post_rst_valid", bus.out_valid, 1'b1);
        check("post_rst_count", bus.count, 6'd23);
        drain();

`ifdef NORMALIZE_SIGNED_EN
        // Redundant sign bits.
        bus.signed_mode = 1'b1;
        bus.in_valid    = 1'b1;
        bus.opA = 32'hFFFF_8000; step();
        bus.opA = 32'h0000_4000; step();
        bus.opA = 32'hFFFF_FFFF; step();
        bus.opA = 32'h0000_0000; step();
        drain();
        bus.signed_mode = 1'b0;
`endif

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            tmp = $urandom;
            tmp = tmp >> $urandom_range(0, 32);
`ifdef NORMALIZE_SIGNED_EN
            bus.signed_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) tmp = ~tmp;
`endif
            bus.opA       = tmp;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/normalizer_pipe.md
Name: normalizer_pipe

Overview:
- Two-stage pipelined normalizer; the inverse of the barrel shifter unit.
- The shifter applies a given shift amount. This block finds the left-shift amount that brings the leading significant bit to the MSB, and outputs both the count and the normalized operand.
- Serves the datapath's CLZ instruction and the soft-float normalize step.
- Valid/ready handshake on both sides, with backpressure.

Parameters:
- WIDTH, 32, operand width; only 32 is supported. Stage split is fixed: coarse bytes, then fine bits.
- CNTW, 6, count width; must hold the value WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  opA is valid this cycle.
- in_ready  output  1  stage 1 accepts this cycle.
- opA  input  WIDTH  operand.
- signed_mode  input  1  present only with NORMALIZE_SIGNED_EN; 1 = count redundant sign bits.
- out_valid  output  1  result, count and zero are valid.
- out_ready  input  1  consumer accepts this cycle.
- result  output  WIDTH  opA shifted left by count.
- count  output  CNTW  shift amount found.
- zero  output  1  opA was 0.

Behaviour:
- Reset (async, resetn=0):
  - s1_valid = s2_valid = 0, so out_valid=0.
  - All data registers are cleared: result=0, count=0, zero=0.
  - in_ready=1 once reset is released.
- Handshake:
  - A transfer occurs when valid and ready are both 1 in the same cycle.
  - s2_adv = !s2_valid | out_ready.
  - in_ready = !s1_valid | s2_adv. This is combinational from out_ready; there is no skid buffer.
- Latency: an accepted input appears on the outputs 2 cycles later if not stalled. Throughput is 1 per cycle.
- Stage 1 (coarse), on acceptance:
  - k = number of leading all-zero bytes of opA, capped at 3.
  - Register: opA << 8k, coarse count 8k, zero flag (opA==0).
  - If nothing is accepted but s2_adv=1, s1_valid is cleared.
- Stage 2 (fine), when s2_adv and s1_valid:
  - f = leading zeros of the top byte of the partial value (0..7).
  - Register: result = partial << f, count = 8k+f, zero.
  - If s1_valid=0 while s2_adv=1, s2_valid is cleared.
  - The outputs hold their last values while out_valid=0.
- Zero input: count=WIDTH (32), result=0, zero=1. The top-byte search is bypassed.
- Stall: while out_valid=1 and out_ready=0, all outputs are held stable. Stage 1 still fills if it is empty. Maximum in flight is 2 operands.
- Simultaneous events:
  - A stage that unloads and reloads in the same cycle (s1_valid=1, s2_adv=1, new input accepted) keeps valid=1 and passes data through.
  - Ordering is strictly FIFO.
- Reset mid-operation: in-flight operands are discarded and no output is produced for them.

Optional Feature:
- Macro NORMALIZE_SIGNED_EN.
- Defined: the signed_mode port exists. When signed_mode=1:
  - The leading-bit search runs on opA XOR {WIDTH{opA[WIDTH-1]}}.
  - count = (number of leading copies of the sign bit) - 1, i.e. redundant sign bits, range 0..31.
  - result = opA << count.
  - opA=0 or opA=all-ones give count=31 and result=opA<<31; zero=1 only for 0.
  - signed_mode is pipelined alongside the data.
- Undefined: the port is absent and the behaviour is unsigned CLZ as above.

Test Plan:
- opA=0x00010000, out_ready=1 -> 2 cycles later: count=15, result=0x80000000, zero=0.
- Back-to-back opA=0x00000001, then 0x80000000, then 0x00000000 -> consecutive outputs:
  - (31, 0x80000000, 0)
  - (0, 0x80000000, 0)
  - (32, 0x00000000, 1)
- Backpressure: out_ready=0; issue 0x0000FF00, 0x00F00000, 0x12345678 on consecutive cycles.
  - in_ready falls to 0 after 2 accepts; the third operand is held.
  - Outputs stay stable at count=16 while stalled.
  - After out_ready=1, outputs appear in order with counts 16, 8, 3.
  - Nothing is lost or duplicated.
- Assert resetn=0 with 2 operands in flight -> out_valid=0 and result=count=0 immediately. After release, no stale output appears and the next operand returns after 2 cycles.
- (NORMALIZE_SIGNED_EN) signed_mode=1:
  - opA=0xFFFF8000 -> count=16, result=0x80000000.
  - opA=0x00004000 -> count=16, result=0x40000000.
  - opA=0xFFFFFFFF -> count=31, result=0x80000000, zero=0.
